// File: rtl/delay_line_sequencer.sv
// Burst sequencer for a fixed-latency delay line: paces upstream reads, flags
// valid/last/index on the delay-line output, and flushes stale data on abort.
module delay_line_sequencer #(
  parameter int unsigned DELAY     = 32,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_abort,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_rd_en,
  output logic                 o_out_valid,
  output logic                 o_out_last,
  output logic [LEN_WIDTH-1:0] o_out_idx,
  output logic                 o_done
);

  localparam int unsigned DW = $clog2(DELAY + 1);
  localparam logic [DW-1:0] DLY_INIT = DW'(DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] feed_left_q, feed_left_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]        dly_q, dly_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      feed_left_q <= '0;
      idx_q       <= '0;
      dly_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      feed_left_q <= feed_left_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  // Next state: feed counter and output counter advance independently in RUN;
  // dly_q counts down the delay-line latency in RUN and the drain in FLUSH.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    feed_left_d = feed_left_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    ready_d     = ready_q;
    rd_d        = rd_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort && (i_len != '0)) begin
          state_d     = ST_RUN;
          len_d       = i_len;
          feed_left_d = i_len - LEN_WIDTH'(1);
          dly_d       = DLY_INIT;
          ready_d     = 1'b0;
          rd_d        = 1'b1;
        end
      end

      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_FLUSH;
          dly_d   = DLY_INIT;
          rd_d    = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          idx_d   = '0;
        end else begin
          if (rd_q) begin
            if (feed_left_q != '0) feed_left_d = feed_left_q - LEN_WIDTH'(1);
            else                   rd_d        = 1'b0;
          end
          if (dly_q != '0) begin
            dly_d = dly_q - DW'(1);
            // First word reaches the delay-line output next cycle
            if (dly_q == DW'(1)) begin
              valid_d = 1'b1;
              idx_d   = '0;
              last_d  = (len_q == LEN_WIDTH'(1));
            end
          end else if (valid_q) begin
            if (last_q) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              idx_d   = '0;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_q + LEN_WIDTH'(1);
              last_d = ((idx_q + LEN_WIDTH'(2)) == len_q);
            end
          end
        end
      end

      ST_FLUSH: begin
        if (dly_q == DW'(1)) begin
          state_d = ST_IDLE;
          dly_d   = '0;
          ready_d = 1'b1;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        rd_d    = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        idx_d   = '0;
      end
    endcase

    busy_d = ~ready_d;
  end

  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_rd_en     = rd_q;
  assign o_out_valid = valid_q;
  assign o_out_last  = last_q;
  assign o_out_idx   = idx_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Bench for delay_line_sequencer: directed scenarios plus random traffic checked
// against a burst-timing model and an end-to-end data check through a delay line.
module tb_delay_line_sequencer;

  localparam int unsigned D  = 32;
  localparam int unsigned LW = 16;
  localparam int          DI = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic          o_ready, o_busy, o_rd_en, o_out_valid, o_out_last, o_done;
  logic [LW-1:0] o_out_idx;

  logic [7:0] din = 8'd0;
  logic [7:0] dl [D];
  logic [7:0] dl_out;
  logic [7:0] word_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Burst model: accepted-start cycle, length, abort cycle (-1 = none)
  int m_valid = 0;
  int m_s     = 0;
  int m_len   = 0;
  int m_abort = -1;

  delay_line_sequencer #(.DELAY(D), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_abort     (i_abort),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_rd_en     (o_rd_en),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .o_out_idx   (o_out_idx),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // The controlled delay line: D stages, no reset, no enable
  always @(posedge clk) begin
    for (int i = D - 1; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= din;
  end
  assign dl_out = dl[D-1];

  // Expected {ready, busy, rd_en, valid, last, done, idx} for the current cycle
  function automatic logic [LW+5:0] exp_vec();
    int   rel, idx;
    logic rdy, rd, vl, ls, dn;
    rdy = 1'b1; rd = 1'b0; vl = 1'b0; ls = 1'b0; dn = 1'b0; idx = 0;
    if (m_valid != 0) begin
      rel = cyc - m_s;
      rdy = !(rel >= 1 && rel <= m_len + DI);
      rd  = (rel >= 1 && rel <= m_len);
      vl  = (rel >= DI + 1 && rel <= m_len + DI);
      ls  = (rel == m_len + DI);
      dn  = (rel == m_len + DI + 1);
      if (vl) idx = rel - 1 - DI;
      if (m_abort >= 0 && cyc > m_abort) begin
        rd = 1'b0; vl = 1'b0; ls = 1'b0; dn = 1'b0; idx = 0;
        rdy = (cyc >= m_abort + DI + 1);
      end
    end
    return {rdy, !rdy, rd, vl, ls, dn, LW'(idx)};
  endfunction

  // One clock cycle: compare mid-cycle, then advance the model at the edge
  task automatic step(input string tag);
    logic [LW+5:0] e, o;
    @(negedge clk);
    e = exp_vec();
    o = {o_ready, o_busy, o_rd_en, o_out_valid, o_out_last, o_done, o_out_idx};
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, o, e);
    end
    if (o_rd_en === 1'b1) word_q.push_back(din);
    if (o_out_valid === 1'b1) begin
      total++;
      if (word_q.size() == 0 || dl_out !== word_q[0]) begin
        bad++;
        $display("FAIL %s_data cyc=%0d got=%h expected=%h", tag, cyc, dl_out,
                 (word_q.size() == 0) ? 8'hxx : word_q[0]);
      end
      if (word_q.size() != 0) void'(word_q.pop_front());
    end
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0;
      word_q.delete();
    end else begin
      e = exp_vec();
      if (e[LW+5] && i_start && !i_abort && i_len != '0) begin
        m_valid = 1; m_s = cyc; m_len = int'(i_len); m_abort = -1;
      end else if (m_valid != 0 && !e[LW+5] && i_abort && m_abort < 0) begin
        m_abort = cyc;
        word_q.delete();
      end
    end
    cyc++;
    #1;
    din = 8'($urandom);
  endtask

  task automatic idle_steps(input string tag, input int n);
    i_start = 1'b0; i_abort = 1'b0; i_len = '0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic test_reset();
    logic [LW+5:0] o;
    #2 rst_n = 1'b0;
    #1;
    o = {o_ready, o_busy, o_rd_en, o_out_valid, o_out_last, o_done, o_out_idx};
    total++;
    if (o !== {6'b100000, LW'(0)}) begin
      bad++;
      $display("FAIL reset_values got=%h expected=%h", o, {6'b100000, LW'(0)});
    end
    idle_steps("reset_hold", 3);
    rst_n = 1'b1;
    idle_steps("reset_release", 3);
  endtask

  task automatic test_basic_len4();
    int s, done_rel;
    s = cyc; done_rel = -1;
    i_start = 1'b1; i_len = LW'(4);
    step("len4");
    i_start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step("len4");
      if (o_done === 1'b1 && done_rel < 0) done_rel = cyc - s;
    end
    total++;
    if (done_rel != 37) begin
      bad++;
      $display("FAIL len4_done_cycle got=%0d expected=37", done_rel);
    end
  endtask

  task automatic test_len1_back_to_back();
    int s;
    s = cyc;
    i_start = 1'b1; i_len = LW'(1);
    step("len1");
    i_start = 1'b0;
    for (int i = 0; i < 33; i++) step("len1");
    total++;
    if (!(o_done === 1'b1 && o_ready === 1'b1 && cyc == s + 34)) begin
      bad++;
      $display("FAIL len1_done got done=%b ready=%b expected done=1 ready=1", o_done, o_ready);
    end
    i_start = 1'b1; i_len = LW'(3);
    step("b2b");
    i_start = 1'b0;
    total++;
    if (o_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rd_en got=%b expected=1", o_rd_en);
    end
    idle_steps("b2b", 45);
  endtask

  task automatic test_overlap();
    int both;
    both = 0;
    i_start = 1'b1; i_len = LW'(50);
    step("overlap");
    i_start = 1'b0;
    for (int i = 0; i < 90; i++) begin
      step("overlap");
      if (o_rd_en === 1'b1 && o_out_valid === 1'b1) both++;
    end
    total++;
    if (both != 18) begin
      bad++;
      $display("FAIL overlap_cycles got=%0d expected=18", both);
    end
  endtask

  task automatic test_abort();
    int s, dones;
    s = cyc; dones = 0;
    i_start = 1'b1; i_len = LW'(50);
    step("abort");
    i_start = 1'b0;
    while (cyc < s + 10) step("abort");
    i_abort = 1'b1;
    step("abort");
    i_abort = 1'b0;
    while (cyc < s + 43) begin
      // second abort while flushing must not restart the flush
      i_abort = (cyc == s + 20);
      step("abort_flush");
      if (o_done === 1'b1) dones++;
    end
    i_abort = 1'b0;
    total++;
    if (o_ready !== 1'b1 || dones != 0) begin
      bad++;
      $display("FAIL abort_recover got ready=%b dones=%0d expected ready=1 dones=0", o_ready, dones);
    end
    i_start = 1'b1; i_len = LW'(5);
    step("post_abort");
    i_start = 1'b0;
    idle_steps("post_abort", 45);
  endtask

  task automatic test_ignored();
    int s;
    i_start = 1'b1; i_len = '0;
    step("len_zero");
    i_start = 1'b0;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL len_zero_ready got=%b expected=1", o_ready);
    end
    i_start = 1'b1; i_abort = 1'b1; i_len = LW'(7);
    step("start_abort_idle");
    i_start = 1'b0; i_abort = 1'b0;
    total++;
    if (o_ready !== 1'b1 || o_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL start_abort_idle got ready=%b rd_en=%b expected ready=1 rd_en=0", o_ready, o_rd_en);
    end
    s = cyc;
    i_start = 1'b1; i_len = LW'(6);
    step("start_in_run");
    i_start = 1'b0;
    while (cyc < s + 5) step("start_in_run");
    i_start = 1'b1; i_len = LW'(20);
    step("start_in_run");
    i_start = 1'b0;
    idle_steps("start_in_run", 60);
  endtask

  task automatic test_reset_midburst();
    int s, stale;
    logic [LW+5:0] o;
    s = cyc; stale = 0;
    i_start = 1'b1; i_len = LW'(50);
    step("mid_reset");
    i_start = 1'b0;
    while (cyc < s + 20) step("mid_reset");
    #2 rst_n = 1'b0;
    m_valid = 0;
    word_q.delete();
    #1;
    o = {o_ready, o_busy, o_rd_en, o_out_valid, o_out_last, o_done, o_out_idx};
    total++;
    if (o !== {6'b100000, LW'(0)}) begin
      bad++;
      $display("FAIL async_reset got=%h expected=%h", o, {6'b100000, LW'(0)});
    end
    idle_steps("mid_reset_hold", 2);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step("mid_reset_after");
      if (o_out_valid === 1'b1) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL stale_flagged got=%0d expected=0", stale);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      i_start = ($urandom_range(0, 7) == 0);
      i_len   = LW'($urandom_range(0, 60));
      i_abort = ($urandom_range(0, 39) == 0);
      step("random");
    end
    idle_steps("random_drain", 100);
  endtask

  initial begin
    test_reset();
    test_basic_len4();
    test_len1_back_to_back();
    test_overlap();
    test_abort();
    test_ignored();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
